// File: rtl/mem_store_buffer.sv
// ============================================================================
// Module   : mem_store_buffer
// Purpose  : Serialises byte/half/word stores into little-endian byte writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_store_buffer #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  output logic [ADDR_W-1:0] write_addr,
  output logic [7:0]        write_data,
  output logic              mem_wr,
  output logic              busy,
  output logic              st_done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]        SIZE_ILLEGAL = 2'b11;

  state_t              state, state_n;
  logic [1:0]          cnt, cnt_n;
  logic [1:0]          last, last_n;
  logic [DATA_W-1:0]   data_q, data_q_n;
  logic [ADDR_W-1:0]   write_addr_n;
  logic [7:0]          write_data_n;
  logic                mem_wr_n, busy_n, st_done_n;
  logic                accept;
  logic [1:0]          cnt_inc;
  logic [1:0]          size_last;

  assign st_ready = rst && ((state == IDLE) || (cnt == last));
  assign accept   = st_valid && st_ready;
  assign cnt_inc  = cnt + 2'd1;

  always_comb begin
    size_last = 2'd0;
    case (st_size)
      2'b01:   size_last = 2'd1;
      2'b10:   size_last = 2'd3;
      default: size_last = 2'd0;
    endcase
  end

  // Outputs are registered, so the next-state logic computes the byte that
  // will be on the RAM port during the following cycle.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_n       = last;
    data_q_n     = data_q;
    write_addr_n = '0;
    write_data_n = 8'h00;
    mem_wr_n     = 1'b1;
    busy_n       = 1'b0;
    st_done_n    = 1'b0;

    if ((state == WRITE) && (cnt != last)) begin
      cnt_n        = cnt_inc;
      write_addr_n = write_addr + ADDR_ONE;
      write_data_n = data_q[{cnt_inc, 3'b000} +: 8];
      mem_wr_n     = 1'b0;
      busy_n       = 1'b1;
      st_done_n    = (cnt_inc == last);
    end else if (accept) begin
      data_q_n = st_data;
      cnt_n    = 2'd0;
      if (st_size == SIZE_ILLEGAL) begin
        state_n   = IDLE;
        last_n    = 2'd0;
        st_done_n = 1'b1;
      end else begin
        state_n      = WRITE;
        last_n       = size_last;
        write_addr_n = st_addr;
        write_data_n = st_data[7:0];
        mem_wr_n     = 1'b0;
        busy_n       = 1'b1;
        st_done_n    = (size_last == 2'd0);
      end
    end else begin
      state_n = IDLE;
      cnt_n   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      last       <= 2'd0;
      data_q     <= '0;
      write_addr <= '0;
      write_data <= 8'h00;
      mem_wr     <= 1'b1;
      busy       <= 1'b0;
      st_done    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last       <= last_n;
      data_q     <= data_q_n;
      write_addr <= write_addr_n;
      write_data <= write_data_n;
      mem_wr     <= mem_wr_n;
      busy       <= busy_n;
      st_done    <= st_done_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
// ============================================================================
// Module   : tb_mem_store_buffer
// Purpose  : Scoreboard bench for mem_store_buffer with directed store vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [16:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic [16:0] write_addr;
  logic [7:0]  write_data;
  logic        mem_wr;
  logic        busy;
  logic        st_done;

  mem_store_buffer #(.ADDR_W(17), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_size    (st_size),
    .write_addr (write_addr),
    .write_data (write_data),
    .mem_wr     (mem_wr),
    .busy       (busy),
    .st_done    (st_done)
  );

  typedef struct {
    bit          illegal;
    logic [16:0] addr;
    logic [7:0]  data;
    bit          done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   run = 0;
  int   last_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_wr(input logic [16:0] a, input logic [7:0] d, input bit done);
    exp_t e;
    e.illegal = 1'b0; e.addr = a; e.data = d; e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic push_illegal();
    exp_t e;
    e.illegal = 1'b1; e.addr = '0; e.data = '0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Packed view: {mem_wr, busy, st_done, write_addr, write_data}
  always @(negedge clk) begin
    if (rst) begin
      if (!mem_wr || st_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got mem_wr=%0b addr=0x%0h data=0x%0h done=%0b, required no activity",
                   mem_wr, write_addr, write_data, st_done);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.illegal)
            check("illegal_done", {36'd0, mem_wr, busy, st_done, write_addr, write_data},
                  {36'd0, 1'b1, 1'b0, 1'b1, 17'd0, 8'd0});
          else
            check("write_byte", {36'd0, mem_wr, busy, st_done, write_addr, write_data},
                  {36'd0, 1'b0, 1'b1, e.done, e.addr, e.data});
        end
      end
      if (!mem_wr) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end else begin
      run = 0;
    end
  end

  task automatic send(input logic [16:0] a, input logic [31:0] d, input logic [1:0] sz,
                      output int waits);
    @(negedge clk);
    st_addr = a; st_data = d; st_size = sz; st_valid = 1'b1;
    waits = 0;
    while (!st_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!st_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got st_ready=0 after %0d cycles, required 1", waits);
    end
    @(posedge clk);
    #1 st_valid = 1'b0;
  endtask

  int w;

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {36'd0, mem_wr, busy, st_done, write_addr, write_data},
          {36'd0, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0});
    check("ready_in_reset", {63'd0, st_ready}, 64'd0);
    #1 rst = 1'b1;
    #1 check("ready_after_reset", {63'd0, st_ready}, 64'd1);

    // Word store
    push_wr(17'h00100, 8'hEF, 0); push_wr(17'h00101, 8'hBE, 0);
    push_wr(17'h00102, 8'hAD, 0); push_wr(17'h00103, 8'hDE, 1);
    send(17'h00100, 32'hDEADBEEF, 2'b10, w);
    repeat (6) @(negedge clk);
    #1 check("word_run_len", 64'(last_run), 64'd4);

    // Half store, misaligned
    push_wr(17'h00021, 8'h78, 0); push_wr(17'h00022, 8'h56, 1);
    send(17'h00021, 32'h12345678, 2'b01, w);
    // Byte store
    push_wr(17'h00005, 8'hAB, 1);
    send(17'h00005, 32'h000000AB, 2'b00, w);
    repeat (4) @(negedge clk);

    // Back-to-back word then byte
    push_wr(17'h00010, 8'h44, 0); push_wr(17'h00011, 8'h33, 0);
    push_wr(17'h00012, 8'h22, 0); push_wr(17'h00013, 8'h11, 1);
    push_wr(17'h00200, 8'h77, 1);
    send(17'h00010, 32'h11223344, 2'b10, w);
    send(17'h00200, 32'h00000077, 2'b00, w);
    check("b2b_ready_wait", 64'(w), 64'd3);
    @(negedge clk);
    #1 check("b2b_ready_bytecycle", {63'd0, st_ready}, 64'd1);
    repeat (2) @(negedge clk);
    #1 check("b2b_run_len", 64'(last_run), 64'd5);

    // Address wrap
    push_wr(17'h1FFFE, 8'h01, 0); push_wr(17'h1FFFF, 8'h02, 0);
    push_wr(17'h00000, 8'h03, 0); push_wr(17'h00001, 8'h04, 1);
    send(17'h1FFFE, 32'h04030201, 2'b10, w);
    repeat (6) @(negedge clk);

    // Illegal size
    push_illegal();
    send(17'h00040, 32'hCAFEF00D, 2'b11, w);
    #1 check("illegal_busy", {63'd0, busy}, 64'd0);
    repeat (4) @(negedge clk);

    // Reset in the middle of a word store
    push_wr(17'h00300, 8'h44, 0); push_wr(17'h00301, 8'h33, 0);
    send(17'h00300, 32'h11223344, 2'b10, w);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_outputs", {36'd0, mem_wr, busy, st_done, write_addr, write_data},
          {36'd0, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0});
    check("midreset_ready", {63'd0, st_ready}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("release_ready", {63'd0, st_ready}, 64'd1);
    check("release_queue_drained", 64'(exp_q.size()), 64'd0);

    push_wr(17'h00ABC, 8'h5A, 1);
    send(17'h00ABC, 32'h0000005A, 2'b00, w);
    repeat (4) @(negedge clk);
    #1 check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_idle", {36'd0, mem_wr, busy, st_done, write_addr, write_data},
          {36'd0, 1'b1, 1'b0, 1'b0, 17'd0, 8'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
